// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO.
// Legality helpers are used at elaboration time by the top.
package fifo_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit depth_ok(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit af_ok(
    input int th,
    input int depth
  );
    return (th >= 1) && (th <= depth);
  endfunction

  function automatic bit ae_ok(
    input int th,
    input int depth
  );
    return (th >= 0) && (th <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port,
// one synchronous read port, no reset on storage or read register.
module fifo_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [AW-1:0]     ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Same-address read and write return the old word.
  always_ff @(posedge clk) begin
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Circular-buffer synchronous FIFO with occupancy count,
// almost-full/empty thresholds and overflow/underflow pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_TH  = DEPTH - 1,
  parameter int AE_TH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  pop,
  output logic [DATA_W-1:0]     data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_TH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (!af_ok(AF_TH, DEPTH)) begin : g_bad_af
    $error("AF_TH must be in 1..DEPTH");
  end
  if (!ae_ok(AE_TH, DEPTH)) begin : g_bad_ae
    $error("AE_TH must be in 0..DEPTH-1");
  end

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              push_ok;
  logic              pop_ok;
  logic [DATA_W-1:0] rd_data;
  logic              dout_clr;

  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk (clk),
    .we  (push_ok & ~reset),
    .wa  (wr_ptr),
    .wd  (data_in),
    .re  (pop_ok & ~reset),
    .ra  (rd_ptr),
    .rd  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dout_clr  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        dout_clr <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      overflow  <= push & ~push_ok;
      underflow <= pop & ~pop_ok;
    end
  end

  // The read register has no reset, so mask it until the first pop.
  assign data_out     = dout_clr ? '0 : rd_data;
  assign count        = cnt;
  assign full         = (cnt == FULL_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO built on a circular buffer. It replaces the fixed 4-deep, 4-bit shift-register FIFO with configurable width and depth, a true occupancy count, almost-full/almost-empty thresholds, and overflow/underflow error pulses. It sits between a producer and a consumer in the same clock domain and is the standard buffering element for the sequential designs in this collection.

## Interface
Parameters:
- `DATA_W`, 4: data word width in bits, ≥1.
- `DEPTH`, 4: number of entries. Must be a power of two, ≥2.
- `AF_TH`, DEPTH-1: `almost_full` asserts when count ≥ AF_TH. Range 1..DEPTH.
- `AE_TH`, 1: `almost_empty` asserts when count ≤ AE_TH. Range 0..DEPTH-1.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous reset, active-high.
- `push` input 1: write request.
- `data_in` input DATA_W: write data, sampled when a push is accepted.
- `pop` input 1: read request.
- `data_out` output DATA_W: registered read data.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `almost_full` output 1: count ≥ AF_TH.
- `almost_empty` output 1: count ≤ AE_TH.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: one-cycle pulse when a push is rejected.
- `underflow` output 1: one-cycle pulse when a pop is rejected.

## Operation
- Storage: DEPTH×DATA_W array with write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits wide. Pointers wrap modulo DEPTH through natural binary rollover.
- Accept rules, evaluated on the flags at the clock edge:
  - `push_ok` = push & (!full | pop).
  - `pop_ok` = pop & !empty.
- On `push_ok`: mem[wr_ptr] ← data_in, then wr_ptr increments.
- On `pop_ok`: data_out ← mem[rd_ptr], then rd_ptr increments.
- Otherwise `data_out` holds its value.
- Count update: +1 on push_ok only, −1 on pop_ok only, unchanged when both or neither are accepted.
- Boundary cases:
  - Push while full, no pop: write is dropped, no state change, `overflow` = 1 for one cycle.
  - Push and pop while full: both accepted, count stays DEPTH, the popped word is the oldest entry.
  - Pop while empty: `underflow` = 1 for one cycle, `data_out` holds. If push is also high, the push is accepted and count becomes 1.
  - Push and pop both high while empty: no read-through. New data appears only after a later pop.
- All flags and `count` are registered, or decoded combinationally from the registered count. They never depend combinationally on push/pop.
- Reset: wr_ptr, rd_ptr and count → 0; `data_out` → 0; `empty` = 1, `full` = 0; `almost_empty` = 1 when AE_TH ≥ 0 (always); `almost_full` = 0; `overflow` and `underflow` = 0. Memory contents are not reset. Reset takes priority over push/pop in the same cycle and discards all stored data.

## Timing
- Write latency: a word pushed at edge N can be popped at edge N+1, and appears on `data_out` after that edge.
- Read latency: 1 cycle from the accepted pop edge to valid `data_out`.
- Flags and `count` reflect the accesses accepted at edge N immediately after edge N.
- `overflow` and `underflow` are high for exactly the cycle following the offending edge.
- Full throughput: one push and one pop per cycle, sustained indefinitely.

## Structure
- Shared package/header `fifo_pkg`:
  - `clog2` constant function.
  - Default DATA_W and DEPTH constants.
  - Parameter-legality checks (DEPTH a power of two; threshold ranges), raised as elaboration errors.
- Sub-module `fifo_mem`: simple dual-port register array with one synchronous write port and one synchronous read port, no reset.
- Pointer, count, flag and error-pulse logic stays in `sync_fifo_param`.

## Test plan
All scenarios use DATA_W=4, DEPTH=4, AF_TH=3, AE_TH=1.
- **Reset:** assert reset for 2 cycles → count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_out=0.
- **Fill and drain:** push 0x1, 0x2, 0x3, 0x4 → full=1, count=4, almost_full=1. Pop ×4 → data_out 0x1, 0x2, 0x3, 0x4 in order; then empty=1.
- **Overflow/underflow:** push 0x5 while full → overflow=1 for one cycle, count stays 4. Drain, then pop while empty → underflow=1 for one cycle, data_out holds 0x4.
- **Simultaneous access:**
  - Push+pop while full, data_in=0x9 → data_out=oldest entry, count stays 4.
  - Push+pop while empty, data_in=0x7 → underflow=1, count=1; the next pop returns 0x7.
- **Wrap-around:** 10 cycles of continuous push+pop at count=2 with an incrementing pattern → output order preserved across pointer wrap, count constant at 2.
- **Mid-operation reset:** at count=3, assert reset with push=1 → next cycle count=0, empty=1, and the pushed word is discarded.
